store_queue: RTL

Holds in-flight stores between dispatch and the data cache, and sits directly downstream of the memory block. It allocates a store-queue index at dispatch and captures each store's address, data and bit mask when the memory block executes it. Once the ROB commits a store, the queue drains it in order to the dcache bus arbiter. It also answers store-to-load forwarding queries from the load unit.

---
 rtl/store_queue_pkg.sv | 28 ++
 rtl/store_queue_fwd.sv | 38 +++
 rtl/store_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/store_queue_pkg.sv
// Shared types and constants for the store queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package store_queue_pkg;
    localparam int SQ_DEPTH = 8;
    localparam int SQ_LOG   = $clog2(SQ_DEPTH);

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_REQ  = 2'd1,
        DR_WAIT = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic        valid;
        logic        written;
        logic        committed;
        logic        mmio;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] mask;
    } sq_entry_t;

    // Doubleword-aligned address as seen by the dcache arbiter.
    function automatic logic [63:0] dw_align(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction
endpackage

// File: rtl/store_queue_fwd.sv
// Age-ordered byte merge of matching older stores for load forwarding.
// Latency: combinational; the caller registers the result.
// Backpressure: none, evaluated every cycle.
module sq_forward
    import store_queue_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sq_entry_t          entries_i [DEPTH],
    input  logic [PTR_W-1:0]   head_i,
    input  logic [DEPTH-1:0]   sqmask_i,
    input  logic [63:0]        addr_i,
    output logic [63:0]        data_o,
    output logic [63:0]        mask_o
);
    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest so younger covering bytes overwrite older ones.
    always_comb begin
        data_o = '0;
        mask_o = '0;
        slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (entries_i[slot].valid && entries_i[slot].written &&
                !entries_i[slot].mmio && sqmask_i[slot] &&
                (entries_i[slot].addr[63:3] == addr_i[63:3])) begin
                for (int b = 0; b < 8; b++) begin
                    if (|entries_i[slot].mask[8*b +: 8]) begin
                        data_o[8*b +: 8] = entries_i[slot].data[8*b +: 8];
                        mask_o[8*b +: 8] = entries_i[slot].mask[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/store_queue.sv
// In-order store queue: allocate at dispatch, capture on execute, drain committed stores to dcache.
// Latency: drain request >=1 cycle after commit; forward response 1 cycle after query.
// Backpressure: disp_ready drops when full; drain holds payload until sq2arb_ready, then waits for done.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int PTR_W = SQ_LOG
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               disp_valid,
    output logic               disp_ready,
    output logic               enq_sqidx_flag,
    output logic [PTR_W-1:0]   enq_sqidx,
    input  logic               st_wr_valid,
    input  logic [PTR_W-1:0]   st_wr_sqidx,
    input  logic [63:0]        st_wr_addr,
    input  logic [63:0]        st_wr_data,
    input  logic [63:0]        st_wr_mask,
    input  logic               st_wr_mmio,
    input  logic               commit_valid,
    input  logic               flush_valid,
    input  logic               flush_sqidx_flag,
    input  logic [PTR_W-1:0]   flush_sqidx,
    output logic               sq2arb_valid,
    input  logic               sq2arb_ready,
    output logic [63:0]        sq2arb_addr,
    output logic [63:0]        sq2arb_data,
    output logic [63:0]        sq2arb_mask,
    output logic               sq2arb_mmio,
    input  logic               sq2arb_done,
    input  logic               fwd_req_valid,
    input  logic [DEPTH-1:0]   fwd_req_sqmask,
    input  logic [63:0]        fwd_req_addr,
    output logic               fwd_resp_valid,
    output logic [63:0]        fwd_resp_data,
    output logic [63:0]        fwd_resp_mask
);
    sq_entry_t     entry_q [DEPTH];
    logic [PTR_W:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    drain_state_t  state_q, state_d;
    logic          load_pl;
    logic [63:0]   arb_addr_q, arb_data_q, arb_mask_q;
    logic          arb_mmio_q;
    logic          fwd_vld_q;
    logic [63:0]   fwd_data_q, fwd_mask_q, fwd_data_c, fwd_mask_c;

    logic           full, enq_fire, done_fire;
    logic [PTR_W:0] flush_ptr, kill_cnt;
    logic [DEPTH-1:0] kill;
    sq_entry_t      head_e;

    assign full      = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
    assign enq_fire  = disp_valid && !full && !flush_valid;
    assign done_fire = (state_q == DR_WAIT) && sq2arb_done;
    assign flush_ptr = {flush_sqidx_flag, flush_sqidx};
    assign kill_cnt  = tail_q - flush_ptr;
    assign head_e    = entry_q[head_q[PTR_W-1:0]];

    assign disp_ready     = !full;
    assign enq_sqidx_flag = tail_q[PTR_W];
    assign enq_sqidx      = tail_q[PTR_W-1:0];
    assign sq2arb_valid   = (state_q == DR_REQ);
    assign sq2arb_addr    = arb_addr_q;
    assign sq2arb_data    = arb_data_q;
    assign sq2arb_mask    = arb_mask_q;
    assign sq2arb_mmio    = arb_mmio_q;
    assign fwd_resp_valid = fwd_vld_q;
    assign fwd_resp_data  = fwd_data_q;
    assign fwd_resp_mask  = fwd_mask_q;

    // Entries between the flush point and the old tail die unless already committed.
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = flush_valid && !entry_q[i].committed &&
                      ({1'b0, PTR_W'(PTR_W'(i) - flush_sqidx)} < kill_cnt);
        end
    end

    // Pointer advance; a flush overrides any same-cycle allocation.
    always_comb begin
        head_d = head_q + {{PTR_W{1'b0}}, done_fire};
        cmt_d  = cmt_q  + {{PTR_W{1'b0}}, commit_valid};
        tail_d = flush_valid ? flush_ptr : (tail_q + {{PTR_W{1'b0}}, enq_fire});
    end

    // Drain FSM next state; payload is latched on entry to REQ so it stays stable.
    always_comb begin
        state_d = state_q;
        load_pl = 1'b0;
        case (state_q)
            DR_IDLE: if (head_e.valid && head_e.committed && head_e.written) begin
                state_d = DR_REQ;
                load_pl = 1'b1;
            end
            DR_REQ:  if (sq2arb_ready) state_d = DR_WAIT;
            DR_WAIT: if (sq2arb_done)  state_d = DR_IDLE;
            default: state_d = DR_IDLE;
        endcase
    end

    // Pointer, FSM and drain payload registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            cmt_q      <= '0;
            tail_q     <= '0;
            state_q    <= DR_IDLE;
            arb_addr_q <= '0;
            arb_data_q <= '0;
            arb_mask_q <= '0;
            arb_mmio_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            state_q <= state_d;
            if (load_pl) begin
                arb_addr_q <= dw_align(head_e.addr);
                arb_data_q <= head_e.data;
                arb_mask_q <= head_e.mask;
                arb_mmio_q <= head_e.mmio;
            end
        end
    end

    // Per-entry update; later statements take priority (kill, then drain release).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_wr_valid && (st_wr_sqidx == PTR_W'(i)) && entry_q[i].valid && !kill[i]) begin
                    entry_q[i].written <= 1'b1;
                    entry_q[i].mmio    <= st_wr_mmio;
                    entry_q[i].addr    <= st_wr_addr;
                    entry_q[i].data    <= st_wr_data;
                    entry_q[i].mask    <= st_wr_mask;
                end
                if (commit_valid && (cmt_q[PTR_W-1:0] == PTR_W'(i)))
                    entry_q[i].committed <= 1'b1;
                if (enq_fire && (tail_q[PTR_W-1:0] == PTR_W'(i))) begin
                    entry_q[i].valid     <= 1'b1;
                    entry_q[i].written   <= 1'b0;
                    entry_q[i].committed <= 1'b0;
                end
                if (kill[i]) begin
                    entry_q[i].valid   <= 1'b0;
                    entry_q[i].written <= 1'b0;
                end
                if (done_fire && (head_q[PTR_W-1:0] == PTR_W'(i)))
                    entry_q[i] <= '0;
            end
        end
    end

    sq_forward #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
        .entries_i (entry_q),
        .head_i    (head_q[PTR_W-1:0]),
        .sqmask_i  (fwd_req_sqmask),
        .addr_i    (fwd_req_addr),
        .data_o    (fwd_data_c),
        .mask_o    (fwd_mask_c)
    );

    // Forward response is a one-cycle registered pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_vld_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else begin
            fwd_vld_q  <= fwd_req_valid;
            fwd_data_q <= fwd_req_valid ? fwd_data_c : 64'd0;
            fwd_mask_q <= fwd_req_valid ? fwd_mask_c : 64'd0;
        end
    end
endmodule
